spi_master_5: RTL and testbench
===============================

// Module: spi_master_5
// PURPOSE
//  SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames; initiator counterpart to the
//  on-board SPI slave. Generates sck, mosi and active-low ss from one fabric clock, samples miso,
//  and hands back each received byte with a one-cycle done strobe. Sits between the host-side
//  command logic and the off-chip/peer SPI pins.
// PARAMETERS
//  HALF    4   sck half-period in clk cycles; legal range 4..255 (slave resyncs sck through 2 FFs)
//  CNT_W   8   width of the half-period counter; must hold HALF-1
// PORTS
//  clk      in   1  system clock; all logic on rising edge
//  rst      in   1  synchronous, active-high reset
//  start    in   1  request one 8-bit transfer; accepted only when busy==0
//  keep_ss  in   1  sampled with start: 1 = leave ss low after this byte (burst)
//  din      in   8  byte to transmit; sampled with start
//  busy     out  1  high from the cycle after an accepted start until the block is ready again
//  done     out  1  one-cycle strobe: dout valid
//  dout     out  8  last received byte; holds until the next done
//  sck      out  1  SPI clock, idles low
//  mosi     out  1  master-out; idles high
//  miso     in   1  master-in; sampled on sck rising edge (registered once before use)
//  ss       out  1  slave select, active low
// BEHAVIOUR
//  Reset: sck=0, ss=1, mosi=1, busy=0, done=0, dout=8'h00, FSM=IDLE, counters=0; applies
//   immediately mid-transfer (sck low, ss high next cycle, no done, received bits discarded).
//  FSM states: IDLE, SETUP, SCK_HI, SCK_LO, GAP.
//  IDLE: start&&!busy -> latch din into shift reg, keep_ss into flag; next cycle ss=0,
//   mosi=din[7], busy=1, state SETUP. start while busy is ignored (no queueing).
//  SETUP: sck low for HALF cycles -> SCK_HI.
//  SCK_HI: sck=1 for HALF cycles; on entry (rising edge) shift in registered miso at bit 0.
//  SCK_LO: sck=0 for HALF cycles; on entry (falling edge) mosi=next MSB of shift reg.
//   Bit counter (3 bits) increments per rising edge; after the 8th SCK_LO expires:
//   done=1 for one cycle, dout=received byte, mosi=1.
//   keep_ss=1: ss stays 0, busy=0 that same cycle, state IDLE.
//   keep_ss=0: ss=1 that same cycle, state GAP.
//  GAP: ss high, busy high for HALF cycles (slave reload time) -> IDLE, busy=0.
//  Timing (start sampled in cycle 0, keep_ss=0): ss falls cycle 1; first sck rise cycle 1+HALF;
//   done in cycle 1+17*HALF; busy drops cycle 1+18*HALF. With keep_ss=1, busy drops with done.
//  start in the same cycle busy drops is accepted (back-to-back bursts; ss never rises).
//  Burst with ss held low still runs a full SETUP phase before each byte.
//  sck is a register output, never gated/combinational; exactly 8 rising edges per frame.
//  miso sampled value = the registered copy at the cycle sck register goes 1.
// STRUCTURE
//  Package spi_pkg: FSM state encoding (IDLE..GAP), BITS_PER_FRAME=8, SCK_IDLE=0, MOSI_IDLE=1.
//  Sub-module spi_half_timer: loadable down-counter (CNT_W) with expire pulse, reloaded to
//   HALF-1 on every state entry; the FSM/shift register stay in this module.
// TESTING
//  1 HALF=4, start with din=8'hA5, loopback miso=mosi -> done at cycle 69, dout=8'hA5, 8 sck rises.
//  2 Paired with the SPI slave (slave din=8'h3C), master din=8'hC3 -> master dout=8'h3C,
//    slave dout=8'hC3 with its done strobe; ss high >=HALF cycles between frames.
//  3 Two starts keep_ss=1 then keep_ss=0 (din 8'h01, 8'h80) -> ss low continuously across both
//    bytes, 16 sck rises, two done strobes, ss rises with the second done.
//  4 start pulsed every cycle while busy -> exactly one frame, no extra sck edges.
//  5 rst asserted after 3rd sck rise -> next cycle sck=0, ss=1, busy=0, no done, dout unchanged.
//  6 miso held 1 / held 0 -> dout=8'hFF / 8'h00; mosi=1 whenever idle.

Source files
------------

// File: rtl/spi_master_5_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM encoding, frame size and pin idle levels.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, GAP} state_t;
  localparam int   BITS_PER_FRAME = 8;
  localparam logic SCK_IDLE       = 1'b0;
  localparam logic MOSI_IDLE      = 1'b1;
endpackage

// File: rtl/spi_master_5_half_timer.sv
// Loadable down-counter that times one sck half-period; expire is high while the count sits at zero.
module spi_half_timer
  import spi_pkg::*;
#(
  parameter int HALF  = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CNT_W'(HALF - 1);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/spi_master_5.sv
// SPI mode-0 master, MSB first, 8-bit frames, with optional ss hold for bursts.
module spi_master_5
  import spi_pkg::*;
#(
  parameter int HALF  = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       keep_ss,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);
  localparam int BIT_W = $clog2(BITS_PER_FRAME);

  state_t           state;
  logic [7:0]       tx;
  logic [7:0]       rx;
  logic [BIT_W-1:0] bit_cnt;
  logic             keep;
  logic             miso_q;
  logic             sample;
  logic             expire;
  logic             load;
  logic             accept;

  assign accept = (state == IDLE) && start && !busy;
  // Every state change goes through an expire (or an accept), so reload on exactly those.
  assign load   = accept || ((state != IDLE) && expire);

  spi_half_timer #(.HALF(HALF), .CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .expire (expire)
  );

  // Data path: miso sync, transmit and receive shift registers
  always_ff @(posedge clk) begin
    miso_q <= miso;
    if (accept)
      tx <= din;
    else if ((state == SCK_HI) && expire && (bit_cnt != '0))
      tx <= {tx[6:0], 1'b0};
    if (sample)
      rx <= {rx[6:0], miso_q};
  end

  // Control FSM; bit_cnt wraps to zero after the 8th rising edge, marking the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sck     <= SCK_IDLE;
      ss      <= 1'b1;
      mosi    <= MOSI_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
      bit_cnt <= '0;
      keep    <= 1'b0;
      sample  <= 1'b0;
    end else begin
      done   <= 1'b0;
      sample <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SETUP;
            ss    <= 1'b0;
            mosi  <= din[7];
            busy  <= 1'b1;
            keep  <= keep_ss;
          end
        end
        SETUP: begin
          if (expire) begin
            state   <= SCK_HI;
            sck     <= 1'b1;
            sample  <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        SCK_HI: begin
          if (expire) begin
            state <= SCK_LO;
            sck   <= SCK_IDLE;
            if (bit_cnt != '0)
              mosi <= tx[6];
          end
        end
        SCK_LO: begin
          if (expire) begin
            if (bit_cnt == '0) begin
              done <= 1'b1;
              dout <= rx;
              mosi <= MOSI_IDLE;
              if (keep) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= GAP;
                ss    <= 1'b1;
              end
            end else begin
              state   <= SCK_HI;
              sck     <= 1'b1;
              sample  <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (expire) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_5.sv
// Directed bench for spi_master_5: timing, loopback, slave pairing, burst, start spam, reset.
module tb_spi_master_5;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       keep_ss;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       ss;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int rises    = 0;
  int dones    = 0;
  int ss_rise  = 0;
  logic sck_q  = 1'b0;
  logic ss_q   = 1'b1;

  // miso source: 0 loopback, 1 const high, 2 const low, 3 behavioural slave
  int         miso_mode = 0;
  logic [7:0] sl_sh = 8'hFF;
  logic [7:0] sl_rx = 8'h00;

  int t_ss, t_sck, t_done, t_idle;
  logic ss_at_done;

  always #5 clk = ~clk;

  spi_master_5 #(.HALF(HALF), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .keep_ss (keep_ss),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .ss      (ss)
  );

  assign miso = (miso_mode == 0) ? mosi :
                (miso_mode == 1) ? 1'b1 :
                (miso_mode == 2) ? 1'b0 : sl_sh[7];

  always @(negedge ss) sl_sh = 8'h3C;
  always @(posedge sck) if (!ss) sl_rx = {sl_rx[6:0], mosi};
  always @(negedge sck) if (!ss) sl_sh = {sl_sh[6:0], 1'b1};

  always @(posedge clk) begin
    cyc++;
    if (sck && !sck_q) rises++;
    if (done) dones++;
    if (ss && !ss_q) ss_rise++;
    sck_q <= sck;
    ss_q  <= ss;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; issues one start and records event cycles relative to the start cycle.
  task automatic frame(input logic [7:0] d, input logic k);
    int c0;
    din = d; keep_ss = k; start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    t_ss = -1; t_sck = -1; t_done = -1; t_idle = -1; ss_at_done = 1'b0;
    for (int i = 0; i < 300 && t_idle < 0; i++) begin
      if (t_ss < 0 && !ss) t_ss = cyc - c0;
      if (t_sck < 0 && sck) t_sck = cyc - c0;
      if (t_done < 0 && done) begin t_done = cyc - c0; ss_at_done = ss; end
      if (!busy) t_idle = cyc - c0;
      if (t_idle < 0) @(negedge clk);
    end
  endtask

  initial begin
    int r0, d0;
    rst = 1'b1; start = 1'b0; keep_ss = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 1'b0);
    chk("rst_ss", ss, 1'b1);
    chk("rst_mosi", mosi, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dout", dout, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a frame, after the 3rd sck rise
    miso_mode = 1;
    r0 = rises; d0 = dones;
    din = 8'h5A; keep_ss = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && rises - r0 < 3; i++) @(negedge clk);
    chk("mid_rises", rises - r0, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_sck", sck, 1'b0);
    chk("mid_ss", ss, 1'b1);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_dout", dout, 8'h00);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("mid_no_done", dones - d0, 0);

    // Loopback 0xA5 with full timing
    miso_mode = 0;
    r0 = rises;
    frame(8'hA5, 1'b0);
    chk("lb_ss_fall", t_ss, 1);
    chk("lb_first_sck", t_sck, 1 + HALF);
    chk("lb_done_cyc", t_done, 1 + 17 * HALF);
    chk("lb_busy_drop", t_idle, 1 + 18 * HALF);
    chk("lb_dout", dout, 8'hA5);
    chk("lb_rises", rises - r0, 8);
    chk("lb_mosi_idle", mosi, 1'b1);

    // Constant miso levels
    miso_mode = 1;
    frame(8'h00, 1'b0);
    chk("miso1_dout", dout, 8'hFF);
    miso_mode = 2;
    frame(8'hFF, 1'b0);
    chk("miso0_dout", dout, 8'h00);
    chk("idle_mosi", mosi, 1'b1);

    // Paired with a mode-0 slave returning 0x3C
    miso_mode = 3;
    frame(8'hC3, 1'b0);
    chk("slv_mdout", dout, 8'h3C);
    chk("slv_sdout", sl_rx, 8'hC3);
    chk("slv_gap", t_idle - t_done, HALF);

    // Two-byte burst with ss held low between bytes
    miso_mode = 0;
    r0 = rises; d0 = dones; ss_rise = 0;
    frame(8'h01, 1'b1);
    chk("bu1_busy_drop", t_idle, 1 + 17 * HALF);
    chk("bu1_dout", dout, 8'h01);
    chk("bu1_ss_low", ss, 1'b0);
    frame(8'h80, 1'b0);
    chk("bu2_done_cyc", t_done, 1 + 17 * HALF);
    chk("bu2_ss_at_done", ss_at_done, 1'b1);
    chk("bu2_dout", dout, 8'h80);
    chk("bu_rises", rises - r0, 16);
    chk("bu_dones", dones - d0, 2);
    chk("bu_ss_rises", ss_rise, 1);

    // start held high while busy must not queue another frame
    r0 = rises; d0 = dones;
    din = 8'h3F; keep_ss = 1'b0; start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (80) @(negedge clk);
    chk("spam_rises", rises - r0, 8);
    chk("spam_dones", dones - d0, 1);
    chk("spam_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
